// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared line-memory definitions for the cache-line adapter:
//               line/beat geometry and the adapter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int LINE_W    = 256;
  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = LINE_W / BEAT_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    RD_DONE = 3'd3,
    WR_DATA = 3'd4,
    WR_DONE = 3'd5
  } adapter_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/line_beat_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_beat_buffer
// Description : One cache line of storage addressed in beats. A whole line is
//               loaded when a request is accepted; individual beats are
//               written during read assembly and muxed out during write
//               serialisation.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               load, load_line   - capture a full line
//               beat_we           - write beat_wdata at wr_idx
//               wr_idx, beat_wdata- beat write slot and data
//               merged_line       - stored line with the incoming beat
//                                   already merged at wr_idx
//               rd_idx, beat_rdata- beat read slot and data
// Revision    : 1.0 - initial release
// ============================================================================
module line_beat_buffer #(
  parameter int LINE_W = mem_pkg::LINE_W,
  parameter int BEAT_W = mem_pkg::BEAT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [LINE_W-1:0]                    load_line,
  input  logic                                 beat_we,
  input  logic [$clog2(LINE_W/BEAT_W)-1:0]     wr_idx,
  input  logic [BEAT_W-1:0]                    beat_wdata,
  output logic [LINE_W-1:0]                    merged_line,
  input  logic [$clog2(LINE_W/BEAT_W)-1:0]     rd_idx,
  output logic [BEAT_W-1:0]                    beat_rdata
);

  logic [LINE_W-1:0] r_line;

  // The merged view lets the owner register a complete line in the same
  // cycle that the final beat arrives.
  always_comb begin
    merged_line                          = r_line;
    merged_line[wr_idx*BEAT_W +: BEAT_W] = beat_wdata;
  end

  assign beat_rdata = r_line[rd_idx*BEAT_W +: BEAT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (load) begin
      r_line <= load_line;
    end else if (beat_we) begin
      r_line <= merged_line;
    end
  end

endmodule : line_beat_buffer
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Responder for the arbiter's line-memory interface. Each
//               cache-line read or write becomes a fixed-length burst of
//               beats on the DRAM-side bus; one transaction in flight.
// Ports       : clk, rst                      - clock, async active-high reset
//               bmem_addr/read/write/wdata    - line request from arbiter
//               r_resp, w_resp                - one-cycle completion pulses
//               bmem_rdata, bmem_raddr        - completed read line/address
//               dram_addr/read/write/wdata    - burst command and write beats
//               dram_ready                    - command/beat accepted
//               dram_rvalid, dram_rdata       - returned read beats
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = mem_pkg::LINE_W,
  parameter int BEAT_W = mem_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bmem_addr,
  input  logic              bmem_read,
  input  logic              bmem_write,
  input  logic [LINE_W-1:0] bmem_wdata,
  output logic              r_resp,
  output logic              w_resp,
  output logic [LINE_W-1:0] bmem_rdata,
  output logic [ADDR_W-1:0] bmem_raddr,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_read,
  output logic              dram_write,
  output logic [BEAT_W-1:0] dram_wdata,
  input  logic              dram_ready,
  input  logic              dram_rvalid,
  input  logic [BEAT_W-1:0] dram_rdata
);

  import mem_pkg::*;

  localparam int BURST_LEN = LINE_W / BEAT_W;
  localparam int CNT_W     = $clog2(BURST_LEN);
  localparam int OFS_W     = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BURST_LEN - 1);

  adapter_state_t    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic              w_load;
  logic              w_beat_we;
  logic [CNT_W-1:0]  w_next_idx;
  logic [LINE_W-1:0] w_merged_line;
  logic [BEAT_W-1:0] w_next_beat;
  logic [ADDR_W-1:0] w_aligned_addr;

  // The line buffer is loaded on every accepted request; for reads the
  // contents are fully overwritten by returned beats.
  assign w_load         = (r_state == IDLE) && (bmem_read || bmem_write);
  assign w_beat_we      = (r_state == RD_DATA) && dram_rvalid;
  // dram_wdata is registered, so the beat after the one being accepted is
  // prepared one cycle ahead.
  assign w_next_idx     = r_cnt + CNT_W'(1);
  assign w_aligned_addr = {bmem_addr[ADDR_W-1:OFS_W], OFS_W'(0)};

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_line_beat_buffer (
    .clk         (clk),
    .rst         (rst),
    .load        (w_load),
    .load_line   (bmem_wdata),
    .beat_we     (w_beat_we),
    .wr_idx      (r_cnt),
    .beat_wdata  (dram_rdata),
    .merged_line (w_merged_line),
    .rd_idx      (w_next_idx),
    .beat_rdata  (w_next_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_resp     <= 1'b0;
      w_resp     <= 1'b0;
      bmem_rdata <= '0;
      bmem_raddr <= '0;
      dram_addr  <= '0;
      dram_read  <= 1'b0;
      dram_write <= 1'b0;
      dram_wdata <= '0;
    end else begin
      r_resp <= 1'b0;
      w_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // Write wins when both requests are presented together.
          if (bmem_write) begin
            r_state    <= WR_DATA;
            r_addr     <= bmem_addr;
            dram_addr  <= w_aligned_addr;
            dram_write <= 1'b1;
            dram_wdata <= bmem_wdata[BEAT_W-1:0];
          end else if (bmem_read) begin
            r_state    <= RD_CMD;
            r_addr     <= bmem_addr;
            dram_addr  <= w_aligned_addr;
            dram_read  <= 1'b1;
          end
        end

        RD_CMD: begin
          if (dram_ready) begin
            r_state   <= RD_DATA;
            r_cnt     <= '0;
            dram_read <= 1'b0;
          end
        end

        RD_DATA: begin
          if (dram_rvalid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST_BEAT) begin
              r_state    <= RD_DONE;
              bmem_rdata <= w_merged_line;
              bmem_raddr <= r_addr;
              r_resp     <= 1'b1;
            end
          end
        end

        RD_DONE: begin
          r_state <= IDLE;
        end

        WR_DATA: begin
          if (dram_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_LAST_BEAT) begin
              r_state    <= WR_DONE;
              dram_write <= 1'b0;
              w_resp     <= 1'b1;
            end else begin
              dram_wdata <= w_next_beat;
            end
          end
        end

        WR_DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : cacheline_adapter
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Directed self-checking bench for cacheline_adapter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [255:0] bmem_wdata;
  logic         r_resp;
  logic         w_resp;
  logic [255:0] bmem_rdata;
  logic [31:0]  bmem_raddr;
  logic [31:0]  dram_addr;
  logic         dram_read;
  logic         dram_write;
  logic [63:0]  dram_wdata;
  logic         dram_ready;
  logic         dram_rvalid;
  logic [63:0]  dram_rdata;

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .r_resp      (r_resp),
    .w_resp      (w_resp),
    .bmem_rdata  (bmem_rdata),
    .bmem_raddr  (bmem_raddr),
    .dram_addr   (dram_addr),
    .dram_read   (dram_read),
    .dram_write  (dram_write),
    .dram_wdata  (dram_wdata),
    .dram_ready  (dram_ready),
    .dram_rvalid (dram_rvalid),
    .dram_rdata  (dram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Activity counters sampled on the active edge.
  int n_rresp  = 0;
  int n_wresp  = 0;
  int n_rd_cyc = 0;
  int cap_n    = 0;
  logic [63:0] cap [64];

  always @(posedge clk) begin
    if (r_resp)    n_rresp  <= n_rresp + 1;
    if (w_resp)    n_wresp  <= n_wresp + 1;
    if (dram_read) n_rd_cyc <= n_rd_cyc + 1;
    if (dram_write && dram_ready) begin
      cap[cap_n & 63] <= dram_wdata;
      cap_n           <= cap_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Fixed-timing write with ready held high; the request stays up through
  // the done edge to show it is not re-accepted.
  task automatic run_write(input string tag, input logic [31:0] a, input logic [255:0] l);
    @(negedge clk);
    bmem_addr = a; bmem_wdata = l; bmem_write = 1'b1; dram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_wdata"}, 256'(dram_wdata), 256'(l[i*64 +: 64]));
    end
    @(negedge clk);
    chk({tag, "_wresp"}, 256'(w_resp), 256'(1'b1));
    @(negedge clk);
    chk({tag, "_no_retrig"}, 256'({w_resp, dram_write}), 256'(2'b00));
    bmem_write = 1'b0;
  endtask

  // Fixed-timing read: command accepted immediately, beats back-to-back.
  task automatic run_read(input string tag, input logic [31:0] a, input logic [255:0] l);
    @(negedge clk);
    bmem_addr = a; bmem_read = 1'b1; dram_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dram_rvalid = 1'b1; dram_rdata = l[i*64 +: 64];
    end
    @(negedge clk);
    dram_rvalid = 1'b0; bmem_read = 1'b0;
    chk({tag, "_rresp"}, 256'(r_resp), 256'(1'b1));
    chk({tag, "_rdata"}, bmem_rdata, l);
    chk({tag, "_raddr"}, 256'(bmem_raddr), 256'(a));
    @(negedge clk);
    chk({tag, "_rresp_clr"}, 256'(r_resp), 256'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0]  b1, b2, b3, b4;
  logic [63:0]  cb [4];
  int           gap [4];
  int           wpat [6];
  logic [255:0] line_t2, line_w, line_e, line_f, line_g, mem_line;
  int           s_rresp, s_wresp, s_rdcyc, s_cap, idx;

  initial begin
    b1 = 64'h1111_1111_1111_1111; b2 = 64'h2222_2222_2222_2222;
    b3 = 64'h3333_3333_3333_3333; b4 = 64'h4444_4444_4444_4444;
    cb[0] = 64'hC0DE_0000_0000_00C1; cb[1] = 64'hC0DE_0000_0000_00C2;
    cb[2] = 64'hC0DE_0000_0000_00C3; cb[3] = 64'hC0DE_0000_0000_00C4;
    line_t2 = {cb[3], cb[2], cb[1], cb[0]};
    gap[0] = 1; gap[1] = 0; gap[2] = 3; gap[3] = 2;
    wpat[0] = 1; wpat[1] = 0; wpat[2] = 1; wpat[3] = 1; wpat[4] = 0; wpat[5] = 1;
    line_w = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
              64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    line_e = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
              64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    line_f = {64'hF4F4_0000_0000_0000, 64'hF3F3_0000_0000_0000,
              64'hF2F2_0000_0000_0000, 64'hF1F1_0000_0000_0000};
    line_g = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5A5A_A5A5_5A5A_A5A5, 64'h0F0F_F0F0_0F0F_F0F0};

    rst = 1'b1; bmem_addr = '0; bmem_read = 1'b0; bmem_write = 1'b0;
    bmem_wdata = '0; dram_ready = 1'b0; dram_rvalid = 1'b0; dram_rdata = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 256'({r_resp, w_resp, dram_read, dram_write}), 256'(4'b0000));
    chk("rst_rdata", bmem_rdata, 256'(0));
    chk("rst_addrs", 256'({bmem_raddr, dram_addr, dram_wdata}), 256'(0));
    rst = 1'b0;

    // ---- read, no stalls ----
    s_rresp = n_rresp;
    @(negedge clk);
    bmem_addr = 32'h0000_1234; bmem_read = 1'b1; dram_ready = 1'b1;
    @(negedge clk);
    chk("t1_dram_read", 256'(dram_read), 256'(1'b1));
    chk("t1_dram_addr", 256'(dram_addr), 256'(32'h0000_1220));
    @(negedge clk);
    chk("t1_cmd_drop", 256'(dram_read), 256'(1'b0));
    dram_rvalid = 1'b1; dram_rdata = b1;
    @(negedge clk); dram_rdata = b2;
    @(negedge clk); dram_rdata = b3;
    @(negedge clk);
    chk("t1_no_early_resp", 256'(r_resp), 256'(1'b0));
    dram_rdata = b4;
    @(negedge clk);
    dram_rvalid = 1'b0;
    chk("t1_rresp", 256'({r_resp, w_resp}), 256'(2'b10));
    chk("t1_rdata", bmem_rdata, {b4, b3, b2, b1});
    chk("t1_raddr", 256'(bmem_raddr), 256'(32'h0000_1234));
    @(negedge clk);
    chk("t1_done_ignored", 256'({r_resp, dram_read}), 256'(2'b00));
    bmem_read = 1'b0;
    @(negedge clk);
    chk("t1_idle", 256'(dram_read), 256'(1'b0));
    chk("t1_rresp_count", 256'(n_rresp - s_rresp), 256'(1));

    // ---- read with command back-pressure and beat gaps ----
    s_rresp = n_rresp; s_rdcyc = n_rd_cyc;
    bmem_addr = 32'h0000_ABCF; bmem_read = 1'b1; dram_ready = 1'b0;
    @(negedge clk);
    chk("t2_dram_addr", 256'(dram_addr), 256'(32'h0000_ABC0));
    dram_rvalid = 1'b1; dram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("t2_cmd_held", 256'(dram_read), 256'(1'b1));
    @(negedge clk);
    dram_ready = 1'b1; dram_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        @(negedge clk);
        dram_rvalid = 1'b0; dram_ready = ~dram_ready;
      end
      @(negedge clk);
      dram_rvalid = 1'b1; dram_rdata = cb[i];
    end
    @(negedge clk);
    dram_rvalid = 1'b0; bmem_read = 1'b0;
    chk("t2_rresp", 256'(r_resp), 256'(1'b1));
    chk("t2_rdata", bmem_rdata, line_t2);
    chk("t2_raddr", 256'(bmem_raddr), 256'(32'h0000_ABCF));
    @(negedge clk);
    chk("t2_rresp_count", 256'(n_rresp - s_rresp), 256'(1));
    chk("t2_read_cycles", 256'(n_rd_cyc - s_rdcyc), 256'(3));

    // ---- write with back-pressure ----
    s_wresp = n_wresp;
    bmem_addr = 32'h0000_205C; bmem_wdata = line_w; bmem_write = 1'b1; dram_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_wvalid", 256'(dram_write), 256'(1'b1));
      chk("t3_wdata", 256'(dram_wdata), 256'(line_w[idx*64 +: 64]));
      chk("t3_waddr", 256'(dram_addr), 256'(32'h0000_2040));
      dram_ready = wpat[k][0];
      if (wpat[k] == 1) idx++;
    end
    @(negedge clk);
    chk("t3_wresp", 256'({r_resp, w_resp, dram_write}), 256'(3'b010));
    bmem_write = 1'b0;
    @(negedge clk);
    chk("t3_wresp_count", 256'(n_wresp - s_wresp), 256'(1));
    chk("t3_rdata_held", bmem_rdata, line_t2);

    // ---- simultaneous read and write ----
    s_rresp = n_rresp; s_wresp = n_wresp; s_rdcyc = n_rd_cyc;
    bmem_addr = 32'h0000_3000; bmem_wdata = line_e;
    bmem_read = 1'b1; bmem_write = 1'b1; dram_ready = 1'b1;
    @(negedge clk);
    chk("t4_write_first", 256'({dram_write, dram_read}), 256'(2'b10));
    chk("t4_wdata0", 256'(dram_wdata), 256'(line_e[63:0]));
    repeat (4) @(negedge clk);
    chk("t4_wresp", 256'({r_resp, w_resp}), 256'(2'b01));
    bmem_read = 1'b0; bmem_write = 1'b0;
    @(negedge clk);
    chk("t4_idle", 256'({dram_read, dram_write}), 256'(2'b00));
    chk("t4_counts", 256'({32'(n_rresp - s_rresp), 32'(n_wresp - s_wresp),
                          32'(n_rd_cyc - s_rdcyc)}), 256'({32'd0, 32'd1, 32'd0}));

    // ---- reset in the middle of a read burst ----
    s_rresp = n_rresp;
    bmem_addr = 32'h0000_4444; bmem_read = 1'b1; dram_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); dram_rvalid = 1'b1; dram_rdata = 64'h9999_0000_0000_0001;
    @(negedge clk); dram_rdata = 64'h9999_0000_0000_0002;
    @(negedge clk); dram_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_ctrl", 256'({r_resp, w_resp, dram_read, dram_write}), 256'(4'b0000));
    chk("t5_async_rdata", bmem_rdata, 256'(0));
    chk("t5_async_addrs", 256'({bmem_raddr, dram_addr, dram_wdata}), 256'(0));
    @(negedge clk);
    bmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_rresp", 256'(n_rresp - s_rresp), 256'(0));
    run_read("t5_after", 32'h0000_4460, line_f);

    // ---- back-to-back write then read through a memory model ----
    s_cap = cap_n;
    run_write("t6_wr", 32'h0000_5000, line_g);
    mem_line = {cap[(s_cap + 3) & 63], cap[(s_cap + 2) & 63],
                cap[(s_cap + 1) & 63], cap[s_cap & 63]};
    chk("t6_mem_image", mem_line, line_g);
    run_read("t6_rd", 32'h0000_5000, mem_line);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_cacheline_adapter
`default_nettype wire
